// File: rtl/jamma_input_scan_pkg.sv
// jamma_input_scan shared types: scan FSM encoding, player select, counter width.
// Used by jamma_input_scan and input_debounce.
package jamma_input_scan_pkg;

  typedef enum logic [1:0] {
    P1_SETTLE = 2'd0,
    P1_SAMPLE = 2'd1,
    P2_SETTLE = 2'd2,
    P2_SAMPLE = 2'd3
  } scan_state_e;

  localparam logic SEL_P1 = 1'b0;
  localparam logic SEL_P2 = 1'b1;

  localparam int CNT_MAX = 255;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

endpackage

// File: rtl/jamma_input_scan_input_debounce.sv
// input_debounce: one-bit stable/counter cell advanced by the scan strobe.
// JAMMA_DEBOUNCE_EN builds the counter; otherwise a plain enabled register.
module input_debounce
  import jamma_input_scan_pkg::*;
`ifdef JAMMA_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_SCANS = 4
)
`endif
(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic raw_i,
  output logic stable_o
);

  logic stable_q, stable_d;

`ifdef JAMMA_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // count consecutive disagreeing scans, flip once the run is long enough
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (en_i) begin
      if (raw_i == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q + ONE == DEB_MAX) begin
        stable_d = raw_i;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  // run-length counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  // no filtering: take the latest scan sample
  always_comb begin
    stable_d = en_i ? raw_i : stable_q;
  end
`endif

  // stable value, released (high) after reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) stable_q <= 1'b1;
    else          stable_q <= stable_d;
  end

  assign stable_o = stable_d;

endmodule

// File: rtl/jamma_input_scan.sv
// jamma_input_scan: JAMMA mux scanner, synchroniser, debounce, coin stretch.
// Optional macro JAMMA_DEBOUNCE_EN enables per-bit debounce counters.
module jamma_input_scan
  import jamma_input_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
`ifdef JAMMA_DEBOUNCE_EN
  parameter int DEBOUNCE_SCANS = 4,
`endif
  parameter int COIN_HOLD_SCANS = 8
) (
  input  logic       I_CLK,
  input  logic       I_RESET_N,
  input  logic [7:0] I_JJOY,
  input  logic [1:0] I_JCOIN,
  input  logic       I_JTEST,
  input  logic       I_JSERVICE,
  output logic       O_JSELECT,
  output logic [7:0] O_JOY1,
  output logic [7:0] O_JOY2,
  output logic [1:0] O_COIN,
  output logic       O_TEST,
  output logic       O_SERVICE,
  output logic       O_SCAN_DONE
);

  localparam int SETTLE = (SETTLE_CYCLES < 3) ? 3 : SETTLE_CYCLES;
  localparam int SW     = $clog2(SETTLE);
  localparam logic [SW-1:0]    SET_LAST = SW'(SETTLE - 1);
  localparam logic [SW-1:0]    SET_ONE  = SW'(1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(COIN_HOLD_SCANS);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  logic [11:0] async_in, sync1_q, sync2_q;

  assign async_in = {I_JSERVICE, I_JTEST, I_JCOIN, I_JJOY};

  // two-flop synchroniser, idle level is released (high)
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
    end
  end

  scan_state_e state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic sel_q, sel_d;
  logic done_q;
  logic [7:0] raw1_q;
  logic strobe;

  assign strobe = (state_q == P2_SAMPLE);

  // scan sequencer: settle each player, then one sample clock
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      P1_SETTLE: begin
        if (cnt_q == SET_LAST) begin
          state_d = P1_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SET_ONE;
        end
      end
      P1_SAMPLE: state_d = P2_SETTLE;
      P2_SETTLE: begin
        if (cnt_q == SET_LAST) begin
          state_d = P2_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SET_ONE;
        end
      end
      P2_SAMPLE: state_d = P1_SETTLE;
    endcase
    sel_d = (state_d == P2_SETTLE || state_d == P2_SAMPLE)
          ? SEL_P2 : SEL_P1;
  end

  // sequencer registers and player 1 raw capture
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q <= P1_SETTLE;
      cnt_q   <= '0;
      sel_q   <= SEL_P1;
      done_q  <= 1'b0;
      raw1_q  <= 8'hFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      done_q  <= strobe;
      if (state_q == P1_SAMPLE) raw1_q <= sync2_q[7:0];
    end
  end

  // P2 bus and coin/test/service are taken live in P2_SAMPLE
  logic [19:0] raw_all, stab_nxt;

  assign raw_all = {sync2_q[11:8], sync2_q[7:0], raw1_q};

  for (genvar g = 0; g < 20; g++) begin : g_cell
    input_debounce
`ifdef JAMMA_DEBOUNCE_EN
      #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS))
`endif
      u_cell (
        .clk_i   (I_CLK),
        .rst_n_i (I_RESET_N),
        .en_i    (strobe),
        .raw_i   (raw_all[g]),
        .stable_o(stab_nxt[g])
      );
  end

  logic [1:0] coin_stab_q, coin_q, coin_d, fall;
  logic [1:0][CNT_W-1:0] hold_q, hold_d;

  // coin stretch: falling edge (re)loads hold, strobe counts it down
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fall[i]   = coin_stab_q[i] & ~stab_nxt[16+i];
      hold_d[i] = hold_q[i];
      if (fall[i]) begin
        hold_d[i] = HOLD_LD;
      end else if (strobe && hold_q[i] != '0) begin
        hold_d[i] = hold_q[i] - HOLD_ONE;
      end
      coin_d[i] = stab_nxt[16+i] & (hold_d[i] == '0);
    end
  end

  logic [7:0] joy1_q, joy2_q;
  logic test_q, svc_q;

  // registered outputs, all change together on the strobe edge
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      joy1_q      <= 8'hFF;
      joy2_q      <= 8'hFF;
      test_q      <= 1'b1;
      svc_q       <= 1'b1;
      coin_stab_q <= 2'b11;
      coin_q      <= 2'b11;
      hold_q      <= '0;
    end else begin
      joy1_q      <= stab_nxt[7:0];
      joy2_q      <= stab_nxt[15:8];
      test_q      <= stab_nxt[18];
      svc_q       <= stab_nxt[19];
      coin_stab_q <= stab_nxt[17:16];
      coin_q      <= coin_d;
      hold_q      <= hold_d;
    end
  end

  assign O_JSELECT   = sel_q;
  assign O_JOY1      = joy1_q;
  assign O_JOY2      = joy2_q;
  assign O_COIN      = coin_q;
  assign O_TEST      = test_q;
  assign O_SERVICE   = svc_q;
  assign O_SCAN_DONE = done_q;

endmodule

// File: tb/tb_jamma_input_scan.sv
// tb_jamma_input_scan: scan-level model of jamma_input_scan, checked every cycle.
// Follows JAMMA_DEBOUNCE_EN the same way as the design.
module tb_jamma_input_scan;

`ifdef JAMMA_DEBOUNCE_EN
  localparam int DEB = 4;
`else
  localparam int DEB = 1;
`endif
  localparam int PER  = 34;
  localparam int HALF = 17;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] jjoy, p1_bus, p2_bus;
  logic [1:0] jcoin;
  logic jtest, jsvc;
  logic sel, done, test_o, svc_o;
  logic [7:0] joy1, joy2;
  logic [1:0] coin;

  int checks = 0;
  int errors = 0;
  int cyc;
  bit post_rst = 1'b0;

  logic [19:0] hist [0:63];
  logic [19:0] m_stab;
  logic [1:0]  m_coin;
  int          m_fall [2];

  always #5 clk = ~clk;

  // external 2:1 player mux
  assign jjoy = sel ? p2_bus : p1_bus;

  jamma_input_scan dut (
    .I_CLK      (clk),
    .I_RESET_N  (rst_n),
    .I_JJOY     (jjoy),
    .I_JCOIN    (jcoin),
    .I_JTEST    (jtest),
    .I_JSERVICE (jsvc),
    .O_JSELECT  (sel),
    .O_JOY1     (joy1),
    .O_JOY2     (joy2),
    .O_COIN     (coin),
    .O_TEST     (test_o),
    .O_SERVICE  (svc_o),
    .O_SCAN_DONE(done)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // per-scan stimulus {svc,test,coin[1:0],p2,p1}
  function automatic logic [19:0] stim(input int n);
    logic [7:0] p1, p2;
    logic [1:0] c;
    logic t, s;
    p1 = 8'hFF; p2 = 8'hFF; c = 2'b11; t = 1'b1; s = 1'b1;
    if (n >= 2 && n <= 7)   p1 = 8'hFE;
    if (n >= 14 && n <= 16) p1 = 8'hFE;
    if (n >= 20 && n <= 24) c[0] = 1'b0;
    if (n >= 32 && n <= 33) c[0] = 1'b0;
    if (n >= 36 && n <= 37) c[0] = 1'b0;
    if (n >= 44 && n <= 60) begin
      p1 = 8'hA5; p2 = 8'h00; c = 2'b01; t = 1'b0; s = 1'b0;
    end
    return {s, t, c, p2, p1};
  endfunction

  task automatic apply(input int idx, input int n);
    logic [19:0] v;
    v = stim(n);
    hist[idx] = v;
    p1_bus = v[7:0];
    p2_bus = v[15:8];
    jcoin  = v[17:16];
    jtest  = v[18];
    jsvc   = v[19];
  endtask

  // a bit flips once the last DEB scans all disagree with it
  task automatic model_update(input int n);
    bit diff;
    for (int b = 0; b < 20; b++) begin
      if (n + 1 >= DEB) begin
        diff = 1'b1;
        for (int j = 0; j < DEB; j++)
          if (hist[n-j][b] == m_stab[b]) diff = 1'b0;
        if (diff) begin
          m_stab[b] = ~m_stab[b];
          if (b >= 16 && b <= 17 && m_stab[b] == 1'b0)
            m_fall[b-16] = n;
        end
      end
    end
    for (int i = 0; i < 2; i++)
      m_coin[i] = m_stab[16+i] && (n - m_fall[i] >= HOLD);
  endtask

  task automatic literal(input int n);
    case (n)
      1:  check("lit_joy1_s1", joy1, 8'hFF);
      2:  check("lit_joy1_s2", joy1, (DEB > 1) ? 8'hFF : 8'hFE);
      5:  check("lit_joy1_s5", joy1, 8'hFE);
      15: check("lit_joy1_s15", joy1, (DEB > 1) ? 8'hFF : 8'hFE);
      17: check("lit_joy1_s17", joy1, 8'hFF);
      27: check("lit_coin_s27", coin, 2'b10);
      28: check("lit_coin_s28", coin, (DEB > 1) ? 2'b10 : 2'b11);
      31: check("lit_coin_s31", coin, 2'b11);
      43: check("lit_coin_s43", coin, (DEB > 1) ? 2'b11 : 2'b10);
      49: begin
        check("lit_joy1_s49", joy1, 8'hA5);
        check("lit_joy2_s49", joy2, 8'h00);
        check("lit_coin_s49", coin, 2'b01);
        check("lit_test_s49", test_o, 1'b0);
        check("lit_svc_s49", svc_o, 1'b0);
      end
      default: ;
    endcase
  endtask

  // compare process: model reset while in reset, full check otherwise
  always @(negedge clk) begin
    if (!rst_n) begin
      m_stab = '1;
      m_coin = 2'b11;
      m_fall[0] = -1000;
      m_fall[1] = -1000;
    end else begin
      if (cyc > 0 && cyc % PER == 0) begin
        model_update(cyc / PER - 1);
        if (!post_rst) literal(cyc / PER - 1);
      end
      check("sel", sel, (cyc % PER) >= HALF);
      check("done", done, cyc > 0 && cyc % PER == 0);
      check("joy1", joy1, m_stab[7:0]);
      check("joy2", joy2, m_stab[15:8]);
      check("coin", coin, m_coin);
      check("test", test_o, m_stab[18]);
      check("svc", svc_o, m_stab[19]);
    end
  end

  initial begin
    int first;
    apply(0, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int n = 1; n <= 54; n++) begin
      repeat (PER) @(posedge clk);
      #1 apply(n, n);
    end
    repeat (20) @(posedge clk);
    #2;
    check("pre_rst_joy2", joy2, 8'h00);
    check("pre_rst_sel", sel, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_sel", sel, 1'b0);
    check("rst_joy1", joy1, 8'hFF);
    check("rst_joy2", joy2, 8'hFF);
    check("rst_coin", coin, 2'b11);
    check("rst_test", test_o, 1'b1);
    check("rst_svc", svc_o, 1'b1);
    check("rst_done", done, 1'b0);
    post_rst = 1'b1;
    apply(0, 100);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    first = 0;
    for (int i = 1; i <= PER; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        first = i;
        break;
      end
    end
    check("first_done", first, PER);
    apply(1, 100);
    repeat (PER) @(posedge clk);
    #1 apply(2, 100);
    repeat (PER + 3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
